// File: rtl/cronometro_pkg.sv
// -----------------------------------------------------------------------------
// cronometro_pkg
// Shared definitions for the stopwatch control unit:
//   - cron_state_t : stopwatch state encoding (ZERADO/CONTANDO/PAUSADO/PARADO)
//   - K_*          : bit index of each key inside the 4-bit key/event vectors
//   - PRIO_ORDER   : fixed command priority, highest first
//   - arb_grant()  : one-hot winner among coincident key events
//   - is_running() : true in the states where the prescaler and counter run
// -----------------------------------------------------------------------------
package cronometro_pkg;

   typedef enum logic [1:0] {
      ZERADO   = 2'd0,
      CONTANDO = 2'd1,
      PAUSADO  = 2'd2,
      PARADO   = 2'd3
   } cron_state_t;

   localparam int N_KEYS  = 4;

   localparam int K_ZERO  = 3;
   localparam int K_START = 2;
   localparam int K_LAP   = 1;
   localparam int K_STOP  = 0;

   // Key indices packed two bits each, highest priority in the top pair:
   // zero > stop > lap > start.
   localparam logic [7:0] PRIO_ORDER = {2'(K_ZERO), 2'(K_STOP), 2'(K_LAP), 2'(K_START)};

   // Picks a single winner from the events of one cycle. Losers are simply
   // dropped; nothing is remembered for later cycles.
   function automatic logic [N_KEYS-1:0] arb_grant(input logic [N_KEYS-1:0] events);
      logic [N_KEYS-1:0] grant;
      logic [1:0]        idx;
      grant = '0;
      for (int p = 0; p < N_KEYS; p++) begin
         idx = PRIO_ORDER[2*(N_KEYS-1-p) +: 2];
         if ((grant == '0) && events[idx]) begin
            grant[idx] = 1'b1;
         end
      end
      return grant;
   endfunction

   function automatic logic is_running(input cron_state_t s);
      return (s == CONTANDO) || (s == PAUSADO);
   endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Conditions one asynchronous push-button level into a single-cycle press
// event. A 2-FF synchronizer feeds a stable-run counter; the key must be armed
// (seen low for DEB_LEN consecutive cycles) before DEB_LEN consecutive high
// cycles produce an event, after which it disarms until released again.
//
// Ports:
//   clock     in  : system clock
//   reset     in  : synchronous active-high reset (leaves the key disarmed)
//   key       in  : raw key level, asynchronous to clock
//   key_event out : one-cycle pulse per accepted press (registered)
// -----------------------------------------------------------------------------
module key_debounce #(
   parameter int DEB_LEN = 65536
) (
   input  logic clock,
   input  logic reset,
   input  logic key,
   output logic key_event
);

   localparam int            CW       = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_LEN - 1);

   logic          sync1_reg;
   logic          sync2_reg;
   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;
   logic          armed_reg;
   logic          armed_next;
   logic          event_reg;
   logic          event_next;

   // The level being waited for equals the arm flag: an armed key waits for
   // a high run (press), a disarmed key waits for a low run (release). The
   // opposite level restarts the run. Completing a run flips the arm flag,
   // and only a completed high run is reported as an event.
   always_comb begin
      cnt_next   = '0;
      armed_next = armed_reg;
      event_next = 1'b0;
      if (sync2_reg == armed_reg) begin
         if (cnt_reg == CNT_LAST) begin
            armed_next = ~armed_reg;
            event_next = armed_reg;
         end else begin
            cnt_next = cnt_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         cnt_reg   <= '0;
         armed_reg <= 1'b0;
         event_reg <= 1'b0;
      end else begin
         sync1_reg <= key;
         sync2_reg <= sync1_reg;
         cnt_reg   <= cnt_next;
         armed_reg <= armed_next;
         event_reg <= event_next;
      end
   end

   assign key_event = event_reg;

endmodule

// File: rtl/cronometro_ctrl.sv
// -----------------------------------------------------------------------------
// cronometro_ctrl
// Control unit of the 4-digit BCD stopwatch: debounces the four keys, picks
// one command per cycle, runs the stopwatch state machine, generates the
// count tick and drives the counter / snapshot datapath controls.
//
// Parameters:
//   TICK_DIV : clock cycles per count tick (>= 2)
//   DEB_LEN  : stable cycles needed to accept a key edge (>= 1)
//
// Ports:
//   clock       in  : system clock
//   reset       in  : synchronous active-high reset
//   key3..key0  in  : zero / start / lap / stop keys, asynchronous levels
//   state       out : current state (0 zeroed, 1 counting, 2 lap, 3 stopped)
//   cnt_clr     out : hold the BCD counter at 0000
//   cnt_en      out : one-cycle counter increment
//   cnt_restore out : one-cycle load of the counter from the snapshot
//   snap_load   out : one-cycle capture of the counter into the snapshot
//   disp_sel    out : display source, 0 live counter / 1 snapshot
// -----------------------------------------------------------------------------
module cronometro_ctrl
   import cronometro_pkg::*;
#(
   parameter int TICK_DIV = 500000,
   parameter int DEB_LEN  = 65536
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       key3,
   input  logic       key2,
   input  logic       key1,
   input  logic       key0,
   output logic [1:0] state,
   output logic       cnt_clr,
   output logic       cnt_en,
   output logic       cnt_restore,
   output logic       snap_load,
   output logic       disp_sel
);

   localparam int            PW         = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   logic [N_KEYS-1:0] key_raw;
   logic [N_KEYS-1:0] key_event;
   logic [N_KEYS-1:0] grant;

   cron_state_t       state_reg;
   cron_state_t       state_next;
   logic              restore_pend_reg;
   logic              restore_pend_next;
   logic              snap_load_reg;
   logic              snap_load_next;
   logic              cnt_restore_reg;
   logic              cnt_restore_next;
   logic [PW-1:0]     presc_reg;
   logic [PW-1:0]     presc_next;
   logic              tick;

   // ---------------------------------------------------------------- keys
   assign key_raw[K_ZERO]  = key3;
   assign key_raw[K_START] = key2;
   assign key_raw[K_LAP]   = key1;
   assign key_raw[K_STOP]  = key0;

   generate
      for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
         key_debounce #(
            .DEB_LEN (DEB_LEN)
         ) u_key_debounce (
            .clock     (clock),
            .reset     (reset),
            .key       (key_raw[gi]),
            .key_event (key_event[gi])
         );
      end
   endgenerate

   assign grant = arb_grant(key_event);

   // ------------------------------------------------------ state register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg        <= ZERADO;
         restore_pend_reg <= 1'b0;
         snap_load_reg    <= 1'b0;
         cnt_restore_reg  <= 1'b0;
         presc_reg        <= '0;
      end else begin
         state_reg        <= state_next;
         restore_pend_reg <= restore_pend_next;
         snap_load_reg    <= snap_load_next;
         cnt_restore_reg  <= cnt_restore_next;
         presc_reg        <= presc_next;
      end
   end

   // ---------------------------------------------------------- next state
   // Commands that make no sense in the current state leave everything as is.
   always_comb begin
      state_next = state_reg;
      if (grant[K_ZERO]) begin
         state_next = ZERADO;
      end else if (grant[K_STOP]) begin
         if (is_running(state_reg)) begin
            state_next = PARADO;
         end
      end else if (grant[K_LAP]) begin
         case (state_reg)
            CONTANDO: state_next = PAUSADO;
            PAUSADO:  state_next = CONTANDO;
            default:  state_next = state_reg;
         endcase
      end else if (grant[K_START]) begin
         if ((state_reg == ZERADO) || (state_reg == PARADO)) begin
            state_next = CONTANDO;
         end
      end
   end

   // Transition side effects. The snapshot and restore pulses are registered
   // so they line up with the first cycle of the new state.
   always_comb begin
      restore_pend_next = restore_pend_reg;
      if ((state_next == ZERADO) || (state_next == CONTANDO)) begin
         restore_pend_next = 1'b0;
      end else if ((state_reg == PAUSADO) && (state_next == PARADO)) begin
         // Stopping from the lap view keeps the lap on display; resuming
         // must continue from that value rather than the hidden live count.
         restore_pend_next = 1'b1;
      end

      // A stop taken from the lap view keeps the existing lap snapshot.
      snap_load_next   = (state_reg == CONTANDO) &&
                         ((state_next == PAUSADO) || (state_next == PARADO));
      cnt_restore_next = (state_reg == PARADO) && (state_next == CONTANDO) &&
                         restore_pend_reg;

      // The prescaler only runs while staying inside the running states, so
      // every start or resume begins a full TICK_DIV period from zero.
      presc_next = '0;
      if (is_running(state_reg) && is_running(state_next) && !tick) begin
         presc_next = presc_reg + 1'b1;
      end
   end

   assign tick = is_running(state_reg) && (presc_reg == PRESC_LAST);

   // ------------------------------------------------------ output decode
   always_comb begin
      cnt_clr     = (state_reg == ZERADO);
      disp_sel    = (state_reg == PAUSADO) || (state_reg == PARADO);
      // The counter keeps running behind the lap display; it must not step
      // in the cycle it is being reloaded from the snapshot.
      cnt_en      = tick && !cnt_restore_reg;
      cnt_restore = cnt_restore_reg;
      snap_load   = snap_load_reg;
   end

   assign state = state_reg;

endmodule

// File: tb/tb_cronometro_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cronometro_ctrl
// Self-checking bench for cronometro_ctrl with DEB_LEN=4, TICK_DIV=10.
// A behavioural model (key history windows, transition table, cycles-since-
// start counter) predicts every output each cycle; directed scenarios add
// fixed-number checks for latencies and pulse counts.
// -----------------------------------------------------------------------------
module tb_cronometro_ctrl;

   localparam int TICK_DIV = 10;
   localparam int DEB_LEN  = 4;
   localparam int HLEN     = DEB_LEN + 4;
   // Edges from the first edge that samples a stable high key level to the
   // edge after which the state output has changed: 2 sync + DEB_LEN + 1.
   localparam int LAT      = 2 + DEB_LEN + 1;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       key3  = 1'b0;
   logic       key2  = 1'b0;
   logic       key1  = 1'b0;
   logic       key0  = 1'b0;
   logic [1:0] state;
   logic       cnt_clr;
   logic       cnt_en;
   logic       cnt_restore;
   logic       snap_load;
   logic       disp_sel;

   cronometro_ctrl #(
      .TICK_DIV (TICK_DIV),
      .DEB_LEN  (DEB_LEN)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .key3        (key3),
      .key2        (key2),
      .key1        (key1),
      .key0        (key0),
      .state       (state),
      .cnt_clr     (cnt_clr),
      .cnt_en      (cnt_en),
      .cnt_restore (cnt_restore),
      .snap_load   (snap_load),
      .disp_sel    (disp_sel)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // ------------------------------------------------------------- model
   int m_state = 0;
   int m_run   = 0;   // cycles since the stopwatch last started running
   bit m_pend  = 1'b0;
   bit m_snap  = 1'b0;
   bit m_rest  = 1'b0;
   bit m_armed [4];
   bit m_evt   [4];
   int hist    [4][HLEN];  // sampled key levels per edge; 2 = invalid (reset)
   int hptr    = 0;

   function automatic bit running(input int s);
      return (s == 1) || (s == 2);
   endfunction

   function automatic logic [6:0] dut_vec();
      return {state, cnt_clr, cnt_en, cnt_restore, snap_load, disp_sel};
   endfunction

   function automatic logic [6:0] exp_vec();
      logic       en;
      logic [1:0] s2;
      en = running(m_state) && ((m_run % TICK_DIV) == TICK_DIV - 1) && !m_rest;
      s2 = 2'(m_state);
      return {s2, (m_state == 0), en, m_rest, m_snap, (m_state >= 2)};
   endfunction

   task automatic model_edge();
      logic [3:0] raw;
      int         order [4] = '{3, 0, 1, 2};
      int         win;
      int         old_s;
      int         new_s;
      bit         all1;
      bit         all0;
      int         v;
      raw = {key3, key2, key1, key0};
      if (reset) begin
         m_state = 0; m_run = 0; m_pend = 0; m_snap = 0; m_rest = 0;
         for (int k = 0; k < 4; k++) begin
            m_armed[k] = 0;
            m_evt[k]   = 0;
            for (int j = 0; j < HLEN; j++) hist[k][j] = 2;
            hist[k][hptr] = 0;
            hist[k][(hptr + HLEN - 1) % HLEN] = 0;
         end
      end else begin
         // command accepted on the previous edge
         win = -1;
         for (int i = 0; i < 4; i++) begin
            if (win < 0 && m_evt[order[i]]) win = order[i];
         end
         old_s = m_state;
         new_s = old_s;
         case (win)
            3: new_s = 0;
            0: if (running(old_s)) new_s = 3;
            1: if (old_s == 1) new_s = 2; else if (old_s == 2) new_s = 1;
            2: if (old_s == 0 || old_s == 3) new_s = 1;
            default: new_s = old_s;
         endcase
         m_snap = (old_s == 1) && (new_s == 2 || new_s == 3);
         m_rest = (old_s == 3) && (new_s == 1) && m_pend;
         if (new_s == 0 || new_s == 1) m_pend = 0;
         else if (old_s == 2 && new_s == 3) m_pend = 1;
         if (running(new_s) && running(old_s)) m_run = m_run + 1;
         else m_run = 0;
         m_state = new_s;
         // key windows: DEB_LEN synchronized samples ending two edges back
         hptr = (hptr + 1) % HLEN;
         for (int k = 0; k < 4; k++) begin
            hist[k][hptr] = int'(raw[k]);
            all1 = 1; all0 = 1;
            for (int j = 1; j <= DEB_LEN; j++) begin
               v = hist[k][(hptr - 1 - j + 2 * HLEN) % HLEN];
               if (v != 1) all1 = 0;
               if (v != 0) all0 = 0;
            end
            m_evt[k] = m_armed[k] && all1;
            if (m_armed[k] && all1) m_armed[k] = 0;
            else if (!m_armed[k] && all0) m_armed[k] = 1;
         end
      end
   endtask

   task automatic step();
      @(posedge clock);
      model_edge();
      @(negedge clock);
      cyc++;
   endtask

   task automatic set_keys(input logic [3:0] k);
      {key3, key2, key1, key0} = k;
   endtask

   // ------------------------------------------------------------- tests
   task automatic test_reset();
      reset = 1'b1;
      set_keys(4'b0000);
      step();
      step();
      total++;
      if (dut_vec() !== 7'b00_1_0_0_0_0) begin
         bad++; $display("FAIL reset_value got=%b want=%b", dut_vec(), 7'b0010000);
      end
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         total++;
         if (dut_vec() !== exp_vec()) begin
            bad++; $display("FAIL reset_idle cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_start();
      int t_state = -1;
      int t_en1   = -1;
      int t_en2   = -1;
      for (int i = 1; i <= 60; i++) begin
         set_keys((i <= 20) ? 4'b0100 : 4'b0000);
         step();
         total++;
         if (dut_vec() !== exp_vec()) begin
            bad++; $display("FAIL start_model cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
         end
         if (t_state < 0 && state == 2'd1) t_state = i;
         if (cnt_en && t_en1 < 0) t_en1 = i;
         else if (cnt_en && t_en2 < 0) t_en2 = i;
      end
      total++;
      if (t_state != LAT) begin
         bad++; $display("FAIL start_latency got=%0d want=%0d", t_state, LAT);
      end
      total++;
      if (t_en1 - t_state != TICK_DIV - 1) begin
         bad++; $display("FAIL first_tick got=%0d want=%0d", t_en1 - t_state, TICK_DIV - 1);
      end
      total++;
      if (t_en2 - t_en1 != TICK_DIV) begin
         bad++; $display("FAIL tick_period got=%0d want=%0d", t_en2 - t_en1, TICK_DIV);
      end
      total++;
      if (state !== 2'd1) begin
         bad++; $display("FAIL start_state got=%0d want=1", state);
      end
   endtask

   task automatic test_lap();
      int snaps;
      int en_paused;
      for (int ph = 0; ph < 2; ph++) begin
         snaps = 0; en_paused = 0;
         for (int i = 1; i <= 30; i++) begin
            set_keys((i <= 8) ? 4'b0010 : 4'b0000);
            step();
            total++;
            if (dut_vec() !== exp_vec()) begin
               bad++; $display("FAIL lap_model cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
            end
            if (snap_load) snaps++;
            if (cnt_en && state == 2'd2) en_paused++;
         end
         total++;
         if (snaps != (ph == 0 ? 1 : 0)) begin
            bad++; $display("FAIL lap_snaps phase=%0d got=%0d want=%0d", ph, snaps, (ph == 0 ? 1 : 0));
         end
         total++;
         if ({state, disp_sel} !== (ph == 0 ? 3'b10_1 : 3'b01_0)) begin
            bad++; $display("FAIL lap_state phase=%0d got=%b want=%b", ph, {state, disp_sel}, (ph == 0 ? 3'b101 : 3'b010));
         end
         if (ph == 0) begin
            total++;
            if (en_paused < 2) begin
               bad++; $display("FAIL lap_counting got=%0d want>=2", en_paused);
            end
         end
      end
   endtask

   task automatic test_stop_restore();
      int snaps = 0;
      int en_stopped = 0;
      int restores = 0;
      int clash = 0;
      int t_run = -1;
      int t_rest = -1;
      for (int i = 1; i <= 90; i++) begin
         if (i <= 8) set_keys(4'b0010);
         else if (i > 30 && i <= 38) set_keys(4'b0001);
         else if (i > 60 && i <= 68) set_keys(4'b0100);
         else set_keys(4'b0000);
         step();
         total++;
         if (dut_vec() !== exp_vec()) begin
            bad++; $display("FAIL stop_restore_model cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
         end
         if (i > 30 && i <= 60) begin
            if (snap_load) snaps++;
            if (cnt_en && state == 2'd3) en_stopped++;
         end
         if (i == 60) begin
            total++;
            if (state !== 2'd3) begin
               bad++; $display("FAIL stop_from_lap got=%0d want=3", state);
            end
         end
         if (i > 60) begin
            if (cnt_restore) begin restores++; t_rest = i; end
            if (cnt_restore && cnt_en) clash++;
            if (t_run < 0 && state == 2'd1) t_run = i;
         end
      end
      total++;
      if (snaps != 0 || en_stopped != 0) begin
         bad++; $display("FAIL stop_lap_quiet snaps=%0d en=%0d want=0/0", snaps, en_stopped);
      end
      total++;
      if (restores != 1 || t_rest != t_run || clash != 0) begin
         bad++; $display("FAIL restore_pulse count=%0d at=%0d run_at=%0d clash=%0d want=1/equal/0", restores, t_rest, t_run, clash);
      end
   endtask

   task automatic test_stop_resume();
      int snaps = 0;
      int restores = 0;
      for (int i = 1; i <= 60; i++) begin
         set_keys((i <= 8) ? 4'b0001 : ((i > 30 && i <= 38) ? 4'b0100 : 4'b0000));
         step();
         total++;
         if (dut_vec() !== exp_vec()) begin
            bad++; $display("FAIL stop_resume_model cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
         end
         if (snap_load) snaps++;
         if (cnt_restore) restores++;
      end
      total++;
      if (snaps != 1 || restores != 0 || state !== 2'd1) begin
         bad++; $display("FAIL stop_resume snaps=%0d restores=%0d state=%0d want=1/0/1", snaps, restores, state);
      end
   endtask

   task automatic test_coincide();
      bit saw_stop = 0;
      for (int i = 1; i <= 30; i++) begin
         set_keys((i <= 8) ? 4'b1001 : 4'b0000);
         step();
         total++;
         if (dut_vec() !== exp_vec()) begin
            bad++; $display("FAIL coincide_model cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
         end
         if (state == 2'd3) saw_stop = 1;
      end
      total++;
      if (state !== 2'd0 || cnt_clr !== 1'b1 || saw_stop) begin
         bad++; $display("FAIL coincide state=%0d clr=%b saw_stop=%0d want=0/1/0", state, cnt_clr, saw_stop);
      end
   endtask

   task automatic test_midpress_reset();
      for (int i = 1; i <= 50; i++) begin
         set_keys((i <= 30) ? 4'b0100 : 4'b0000);
         reset = (i == 4 || i == 5);
         step();
         total++;
         if (dut_vec() !== exp_vec()) begin
            bad++; $display("FAIL midpress_model cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
         end
      end
      reset = 1'b0;
      total++;
      if (state !== 2'd0) begin
         bad++; $display("FAIL midpress_discard got=%0d want=0", state);
      end
   endtask

   task automatic test_bounce();
      int changes = 0;
      int t_chg = -1;
      logic [1:0] prev_state;
      for (int i = 1; i <= 30; i++) begin
         set_keys((i <= 8) ? 4'b0100 : 4'b0000);
         step();
      end
      prev_state = state;
      for (int i = 1; i <= 40; i++) begin
         if (i <= 12) set_keys(((((i - 1) / 2) % 2) == 0) ? 4'b0010 : 4'b0000);
         else if (i <= 30) set_keys(4'b0010);
         else set_keys(4'b0000);
         step();
         total++;
         if (dut_vec() !== exp_vec()) begin
            bad++; $display("FAIL bounce_model cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
         end
         if (state !== prev_state) begin changes++; t_chg = i; end
         prev_state = state;
      end
      total++;
      if (changes != 1 || t_chg - 12 != LAT || state !== 2'd2) begin
         bad++; $display("FAIL bounce changes=%0d latency=%0d state=%0d want=1/%0d/2", changes, t_chg - 12, state, LAT);
      end
   endtask

   task automatic test_random();
      logic [3:0] mask;
      int hold;
      int gap;
      int rst_len;
      for (int n = 0; n < 250; n++) begin
         if ($urandom_range(0, 5) == 0) mask = 4'($urandom_range(0, 15));
         else mask = 4'b0001 << $urandom_range(0, 3);
         hold    = $urandom_range(1, 9);
         gap     = $urandom_range(1, 9);
         rst_len = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 2) : 0;
         for (int i = 0; i < hold + gap; i++) begin
            set_keys((i < hold) ? mask : 4'b0000);
            reset = (i < rst_len) && (i >= hold / 2);
            step();
            total++;
            if (dut_vec() !== exp_vec()) begin
               bad++; $display("FAIL random_model cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
            end
         end
         reset = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_lap();
      test_stop_restore();
      test_stop_resume();
      test_coincide();
      test_midpress_reset();
      test_bounce();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cronometro_ctrl.md
# cronometro_ctrl

Control unit for the 4-digit BCD stopwatch. It conditions the four push-button keys and turns each accepted press into one command. It runs the stopwatch state machine (zeroed / counting / lap-paused / stopped) and generates the tick prescaler. It drives the clear, enable, restore and snapshot controls of the BCD counter and snapshot-register datapath, plus the display-source select.

## Interface
Parameters:
- `TICK_DIV`, default 500000: clock cycles per count tick (50 MHz → 100 Hz); legal range ≥ 2.
- `DEB_LEN`, default 65536: consecutive stable synchronized cycles required to accept a key edge; legal range ≥ 1.

Ports (clock and reset first):
- `clock` in 1: single system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high; overrides every other input.
- `key3` in 1: zero command, active-high level, asynchronous to `clock`.
- `key2` in 1: start/resume command.
- `key1` in 1: lap toggle (pause/unpause) command.
- `key0` in 1: stop command.
- `state` out 2: current state.
- `cnt_clr` out 1: clear counter to 0000.
- `cnt_en` out 1: single-cycle increment of the BCD counter.
- `cnt_restore` out 1: single-cycle pulse; load counter from snapshot register.
- `snap_load` out 1: single-cycle pulse; capture counter into snapshot register.
- `disp_sel` out 1: display source; 0 = live counter, 1 = snapshot register.

## Operation
- Key path (per key):
  - 2-FF synchronizer.
  - Debouncer with stable-count filter: a press event is a 1-cycle pulse emitted when the synchronized level has been high for `DEB_LEN` consecutive cycles while the key is armed.
  - The key then disarms and re-arms only after `DEB_LEN` consecutive low cycles.
  - One press produces exactly one event regardless of hold time.
- Arbitration: if events coincide in one cycle, priority is key3 > key0 > key1 > key2. Losers are discarded, not queued.
- States (encoding): ZERADO=0, CONTANDO=1, PAUSADO=2, PARADO=3. Reset enters ZERADO.
- Transitions:
  - key3, any state → ZERADO.
  - key0, from CONTANDO or PAUSADO → PARADO.
  - key1: CONTANDO → PAUSADO; PAUSADO → CONTANDO.
  - key2: ZERADO → CONTANDO; PARADO → CONTANDO.
  - All other command/state pairs are ignored with no side effect, e.g. key1 in ZERADO or PARADO, key2 in CONTANDO or PAUSADO, key0 in ZERADO or PARADO.
- Outputs:
  - `cnt_clr` = (state==ZERADO).
  - `disp_sel` = state is PAUSADO or PARADO.
  - `cnt_en` = tick & state is CONTANDO or PAUSADO. The counter keeps running while the lap is displayed.
- `snap_load` pulses in the first cycle of PAUSADO, and in the first cycle of PARADO when it is entered from CONTANDO. When PARADO is entered from PAUSADO, the snapshot (lap value) is kept.
- Flag `restore_pend`:
  - Set on PAUSADO → PARADO.
  - Cleared on any entry into ZERADO or CONTANDO.
  - On PARADO → CONTANDO with the flag set, `cnt_restore` pulses in the first CONTANDO cycle, so counting resumes from the displayed lap value.
- Prescaler:
  - Counts 0..`TICK_DIV`-1 in CONTANDO and PAUSADO. Tick is asserted for the single cycle in which the count equals `TICK_DIV`-1, then it wraps to 0.
  - Held at 0 in ZERADO and PARADO, so the first tick after start or resume arrives after exactly `TICK_DIV` cycles.
  - `cnt_en` is forced 0 during a `cnt_restore` cycle.

## Timing
- Reset values: `state`=0, `cnt_clr`=1, and `cnt_en`, `cnt_restore`, `snap_load`, `disp_sel` all 0. Prescaler, debouncers (all disarmed-low), and `restore_pend` are cleared.
- Latency from key high to event pulse: 2 synchronizer cycles + `DEB_LEN` cycles.
- The state register updates on the edge following the event pulse.
- The `snap_load` and `cnt_restore` pulses are high during the first cycle in the new state.
- When `cnt_en` and `snap_load` are high in the same cycle, the datapath captures the pre-increment value.
- `reset` asserted mid-press discards the press. The key must be seen low for `DEB_LEN` cycles before its next event.

## Structure
- Package `cronometro_pkg`:
  - State typedef/encoding (ZERADO…PARADO).
  - Key index constants (K_ZERO=3, K_START=2, K_LAP=1, K_STOP=0).
  - The fixed priority order.
- Sub-module `key_debounce`: synchronizer, stable counter, arm flag, event pulse. Instantiated 4×.
- Top level contains the arbiter, FSM, `restore_pend`, prescaler and output decode.

## Test plan
Bench parameters: `DEB_LEN`=4, `TICK_DIV`=10.
- Reset, then key2 held 20 cycles → exactly one event; state 0→1. First `cnt_en` occurs 10 cycles after entering CONTANDO, then every 10 cycles.
- CONTANDO, key1 → `snap_load` pulse, `disp_sel`=1, `cnt_en` continues. Second key1 → state 1, `disp_sel`=0, no `snap_load`.
- PAUSADO, key0 → state 3, `cnt_en` stops, no `snap_load`. Then key2 → state 1 with a `cnt_restore` pulse in its first cycle and no `cnt_en` in that cycle.
- CONTANDO, key0 then key2 → `snap_load` on stop, no `cnt_restore` on resume.
- key0 and key3 events in the same cycle during CONTANDO → state 0, `cnt_clr`=1.
- Key bouncing (toggle every 2 cycles for 12 cycles, then stable high) → exactly one event, with 2 + 4 cycles of latency measured from the start of the stable high.
